qam_frame_buffer_ctrl: RTL and testbench



---
 rtl/qam_frame_buffer_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_qam_frame_buffer_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_frame_buffer_ctrl.sv
// Frame buffer between the hard-decision QAM demapper and the host: captures symbols
// into a FIFO, flags complete frames and streams them out under host read control.
module qam_frame_buffer_ctrl #(
    parameter int SYM_W     = 4,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic                         dclk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sym_valid,
    input  logic [SYM_W-1:0]             sym_data,
    input  logic                         read_enable,
    output logic [SYM_W-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         available,
    output logic                         complete,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_FRAME = LVL_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_READY,
        ST_READOUT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               rd_valid_q, rd_valid_d;
    logic               available_q, available_d;
    logic               complete_q, complete_d;
    logic [SYM_W-1:0]   rd_data_q;

    logic [SYM_W-1:0]   mem [DEPTH];

    logic               full;
    logic               empty;
    logic               active;
    logic               wr_en;
    logic               drop;
    logic               pop;

    // Full/empty come from the registered level, so a same-cycle pop never frees a slot.
    assign full   = (level_q == LVL_FULL);
    assign empty  = (level_q == '0);
    assign active = enable && (state_q != ST_IDLE);
    assign wr_en  = active && sym_valid && !full;
    assign drop   = active && sym_valid && full;
    assign pop    = enable && (state_q == ST_READOUT) && read_enable
                    && (frame_cnt_q < CNT_FRAME) && !empty;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        complete_d  = 1'b0;
        rd_valid_d  = pop;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (level_d >= LVL_FRAME) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (read_enable) begin
                    frame_cnt_d = '0;
                    state_d     = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (pop) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    if (frame_cnt_q == CNT_LAST) begin
                        complete_d = 1'b1;
                        state_d    = (level_d >= LVL_FRAME) ? ST_READY : ST_RECEIVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling flushes the FIFO but keeps the drop history for the host.
        if (!enable) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            frame_cnt_d = '0;
            complete_d  = 1'b0;
            rd_valid_d  = 1'b0;
        end
    end

    assign available_d = (state_d == ST_READY) || (state_d == ST_READOUT);

    always_ff @(posedge dclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            rd_valid_q  <= 1'b0;
            available_q <= 1'b0;
            complete_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            rd_valid_q  <= rd_valid_d;
            available_q <= available_d;
            complete_q  <= complete_d;
        end
    end

    // Symbol storage kept reset-free with a registered read port so it maps to block RAM.
    always_ff @(posedge dclk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sym_data;
        end
    end

    always_ff @(posedge dclk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (pop) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign available = available_q;
    assign complete  = complete_q;
    assign level     = level_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_qam_frame_buffer_ctrl.sv
// Directed bench for qam_frame_buffer_ctrl with SYM_W=4, DEPTH=8, FRAME_LEN=4.
module tb_qam_frame_buffer_ctrl;

    logic        dclk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sym_valid;
    logic [3:0]  sym_data;
    logic        read_enable;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        available;
    logic        complete;
    logic [3:0]  level;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    qam_frame_buffer_ctrl #(
        .SYM_W     (4),
        .DEPTH     (8),
        .FRAME_LEN (4)
    ) dut (
        .dclk        (dclk),
        .reset       (reset),
        .enable      (enable),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .read_enable (read_enable),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .available   (available),
        .complete    (complete),
        .level       (level),
        .drop_cnt    (drop_cnt)
    );

    always #5 dclk = ~dclk;

    task automatic step();
        @(posedge dclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enable      = 1'($urandom);
            sym_valid   = 1'($urandom);
            sym_data    = 4'($urandom);
            read_enable = 1'($urandom);
            step();
        end
        vectors++;
        if ({rd_data, rd_valid, available, complete, level, drop_cnt} !== 27'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd_data=%0d rd_valid=%0b avail=%0b cmpl=%0b level=%0d drop=%0d, want all 0",
                     rd_data, rd_valid, available, complete, level, drop_cnt);
        end
        reset = 1'b0; enable = 1'b1; sym_valid = 1'b0; read_enable = 1'b0; sym_data = 4'd0;
        step();
        vectors++;
        if (level !== 4'd0 || available !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got level=%0d avail=%0b, want 0 0", level, available);
        end
        $display("reset: done");
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            sym_valid = 1'b1; sym_data = 4'(i);
            step();
            vectors++;
            if (level !== 4'(i) || available !== (i == 4) || drop_cnt !== 16'd0) begin
                miscompares++;
                $display("FAIL fill_%0d: got level=%0d avail=%0b drop=%0d, want %0d %0b 0",
                         i, level, available, drop_cnt, i, (i == 4));
            end
            $display("fill: wrote %0d level=%0d avail=%0b", i, level, available);
        end
        sym_valid = 1'b0;
    endtask

    task automatic test_readout();
        read_enable = 1'b1;
        step();
        vectors++;
        if (rd_valid !== 1'b0 || available !== 1'b1) begin
            miscompares++;
            $display("FAIL readout_enter: got rd_valid=%0b avail=%0b, want 0 1", rd_valid, available);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== 4'(i) || complete !== (i == 4)
                || available !== (i != 4) || level !== 4'(4 - i)) begin
                miscompares++;
                $display("FAIL readout_%0d: got v=%0b d=%0d c=%0b a=%0b l=%0d, want 1 %0d %0b %0b %0d",
                         i, rd_valid, rd_data, complete, available, level, i, (i == 4), (i != 4), 4 - i);
            end
            $display("readout: pop %0d data=%0d cmpl=%0b", i, rd_data, complete);
        end
        read_enable = 1'b0;
        step();
        vectors++;
        if (rd_valid !== 1'b0 || complete !== 1'b0 || available !== 1'b0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL readout_after: got v=%0b c=%0b a=%0b l=%0d, want 0 0 0 0",
                     rd_valid, complete, available, level);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            sym_valid = 1'b1; sym_data = 4'(i);
            step();
            vectors++;
            if (level !== 4'((i < 8) ? i + 1 : 8) || drop_cnt !== 16'((i < 8) ? 0 : i - 7)) begin
                miscompares++;
                $display("FAIL overflow_wr%0d: got level=%0d drop=%0d, want %0d %0d",
                         i, level, drop_cnt, (i < 8) ? i + 1 : 8, (i < 8) ? 0 : i - 7);
            end
            $display("overflow: wrote %0d level=%0d drop=%0d", i, level, drop_cnt);
        end
        sym_valid = 1'b0; read_enable = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== 4'(i) || complete !== (i == 3)
                || available !== 1'b1 || level !== 4'(7 - i)) begin
                miscompares++;
                $display("FAIL overflow_rd%0d: got v=%0b d=%0d c=%0b a=%0b l=%0d, want 1 %0d %0b 1 %0d",
                         i, rd_valid, rd_data, complete, available, level, i, (i == 3), 7 - i);
            end
            $display("overflow: pop data=%0d cmpl=%0b", rd_data, complete);
        end
        read_enable = 1'b0;
        step();
        vectors++;
        if (available !== 1'b1 || rd_valid !== 1'b0 || level !== 4'd4) begin
            miscompares++;
            $display("FAIL overflow_ready: got a=%0b v=%0b l=%0d, want 1 0 4", available, rd_valid, level);
        end
    endtask

    task automatic test_concurrent();
        // FIFO holds 4,5,6,7; pops 1,2 and 3,4 carry writes, with a two-cycle pause between.
        logic [1:0] pops;
        pops = 2'd0;
        read_enable = 1'b1;
        step();
        for (int c = 0; c < 6; c++) begin
            if (c == 2 || c == 3) begin
                read_enable = 1'b0; sym_valid = 1'b0;
            end else begin
                read_enable = 1'b1; sym_valid = 1'b1; sym_data = 4'(8 + pops);
            end
            step();
            vectors++;
            if (c == 2 || c == 3) begin
                if (rd_valid !== 1'b0 || level !== 4'd4 || available !== 1'b1 || complete !== 1'b0) begin
                    miscompares++;
                    $display("FAIL concurrent_pause%0d: got v=%0b l=%0d a=%0b c=%0b, want 0 4 1 0",
                             c, rd_valid, level, available, complete);
                end
            end else begin
                if (rd_valid !== 1'b1 || rd_data !== 4'(4 + pops) || level !== 4'd4
                    || available !== 1'b1 || complete !== (pops == 2'd3)) begin
                    miscompares++;
                    $display("FAIL concurrent_pop%0d: got v=%0b d=%0d l=%0d a=%0b c=%0b, want 1 %0d 4 1 %0b",
                             pops, rd_valid, rd_data, level, available, complete, 4 + pops, (pops == 2'd3));
                end
                pops = pops + 2'd1;
            end
            $display("concurrent: cycle %0d v=%0b data=%0d level=%0d", c, rd_valid, rd_data, level);
        end
        read_enable = 1'b0; sym_valid = 1'b0;
        // Fill to full (8..11 plus 12..15), then pop with a write: the write must be dropped.
        for (int i = 12; i < 16; i++) begin
            sym_valid = 1'b1; sym_data = 4'(i);
            step();
        end
        sym_valid = 1'b0; read_enable = 1'b1;
        step();
        sym_valid = 1'b1; sym_data = 4'd0;
        step();
        sym_valid = 1'b0;
        vectors++;
        if (rd_data !== 4'd8 || level !== 4'd7 || drop_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL full_pop_write: got d=%0d l=%0d drop=%0d, want 8 7 3", rd_data, level, drop_cnt);
        end
        $display("concurrent: full pop+write data=%0d level=%0d drop=%0d", rd_data, level, drop_cnt);
    endtask

    task automatic test_abort();
        step();
        vectors++;
        if (rd_data !== 4'd9 || rd_valid !== 1'b1 || level !== 4'd6 || complete !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_pop2: got d=%0d v=%0b l=%0d c=%0b, want 9 1 6 0", rd_data, rd_valid, level, complete);
        end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (rd_valid !== 1'b0 || complete !== 1'b0 || level !== 4'd0
                || available !== 1'b0 || drop_cnt !== 16'd3) begin
                miscompares++;
                $display("FAIL abort_%0d: got v=%0b c=%0b l=%0d a=%0b drop=%0d, want 0 0 0 0 3",
                         i, rd_valid, complete, level, available, drop_cnt);
            end
            $display("abort: cycle %0d level=%0d drop=%0d", i, level, drop_cnt);
        end
        read_enable = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (drop_cnt !== 16'd0 || rd_data !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_reset: got drop=%0d d=%0d, want 0 0", drop_cnt, rd_data);
        end
        $display("abort: reset pulse drop=%0d", drop_cnt);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sym_valid = 1'b0; sym_data = 4'd0; read_enable = 1'b0;
        test_reset();
        test_fill();
        test_readout();
        test_overflow();
        test_concurrent();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
